// File: rtl/input_capture.sv
// Captures the board switches on a debounced key press, using a 4-phase IO request/in_ready handshake.
// State updates on the falling edge of sys_clock. Define INPUT_CAPTURE_DEBOUNCE_EN to add the key debounce counter.
module input_capture #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic        sys_clock,
    input  logic        reset,
    input  logic [1:0]  IO,
    input  logic [15:0] switches,
    input  logic        key,
    output logic [15:0] entrada,
    output logic        in_ready,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE,
        WAIT_PRESS,
        WAIT_RELEASE,
        DONE
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic        w_capture;
    logic        w_io_req;
    logic        w_press;

    logic        r_key_meta;
    logic        r_key_sync;
    logic [15:0] r_sw_meta;
    logic [15:0] r_sw_sync;
    logic        r_key_db;
    logic        r_key_db_d;
    logic [15:0] r_entrada;
    logic        r_in_ready;
    logic        r_busy;

    always_ff @(negedge sys_clock or posedge reset) begin
        if (reset) begin
            r_key_meta <= 1'b1;
            r_key_sync <= 1'b1;
            r_sw_meta  <= 16'h0000;
            r_sw_sync  <= 16'h0000;
        end else begin
            r_key_meta <= key;
            r_key_sync <= r_key_meta;
            r_sw_meta  <= switches;
            r_sw_sync  <= r_sw_meta;
        end
    end

`ifdef INPUT_CAPTURE_DEBOUNCE_EN
    localparam int CNT_W = (DEBOUNCE_CYCLES < 2) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [CNT_W-1:0] r_db_cnt;

    // The level flips on the DEBOUNCE_CYCLES-th consecutive disagreeing cycle.
    always_ff @(negedge sys_clock or posedge reset) begin
        if (reset) begin
            r_db_cnt <= '0;
            r_key_db <= 1'b1;
        end else if (r_key_sync == r_key_db) begin
            r_db_cnt <= '0;
        end else if (r_db_cnt >= CNT_LAST) begin
            r_db_cnt <= '0;
            r_key_db <= r_key_sync;
        end else begin
            r_db_cnt <= r_db_cnt + CNT_W'(1);
        end
    end
`else
    always_ff @(negedge sys_clock or posedge reset) begin
        if (reset) begin
            r_key_db <= 1'b1;
        end else begin
            r_key_db <= r_key_sync;
        end
    end
`endif

    // A press is an edge of the debounced level, so a key held before the request never counts.
    always_ff @(negedge sys_clock or posedge reset) begin
        if (reset) begin
            r_key_db_d <= 1'b1;
        end else begin
            r_key_db_d <= r_key_db;
        end
    end

    assign w_press  = r_key_db_d & ~r_key_db;
    assign w_io_req = (IO == 2'd1);

    always_comb begin
        w_next    = r_state;
        w_capture = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_io_req) begin
                    w_next = WAIT_PRESS;
                end
            end
            WAIT_PRESS: begin
                if (!w_io_req) begin
                    w_next = IDLE;
                end else if (w_press) begin
                    w_next    = WAIT_RELEASE;
                    w_capture = 1'b1;
                end
            end
            WAIT_RELEASE: begin
                if (!w_io_req) begin
                    w_next = IDLE;
                end else if (r_key_db) begin
                    w_next = DONE;
                end
            end
            DONE: begin
                if (!w_io_req) begin
                    w_next = IDLE;
                end
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    // Outputs decode the next state so they line up with r_state after the edge.
    always_ff @(negedge sys_clock or posedge reset) begin
        if (reset) begin
            r_state    <= IDLE;
            r_entrada  <= 16'h0000;
            r_in_ready <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            r_state    <= w_next;
            r_in_ready <= (w_next == DONE);
            r_busy     <= (w_next == WAIT_PRESS) || (w_next == WAIT_RELEASE);
            if (w_capture) begin
                r_entrada <= r_sw_sync;
            end
        end
    end

    assign entrada  = r_entrada;
    assign in_ready = r_in_ready;
    assign busy     = r_busy;

endmodule

// File: tb/tb_input_capture.sv
// Directed bench for input_capture with a queue-based scoreboard; adapts key-pulse expectations
// to whether INPUT_CAPTURE_DEBOUNCE_EN is defined (DEBOUNCE_CYCLES = 4).
module tb_input_capture;

    localparam int HALF = 5;

    logic        sys_clock = 1'b0;
    logic        reset     = 1'b0;
    logic [1:0]  IO        = 2'd0;
    logic [15:0] switches  = 16'h0000;
    logic        key       = 1'b1;
    logic [15:0] entrada;
    logic        in_ready;
    logic        busy;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [15:0] exp_q[$];
    logic        prev_rdy = 1'b0;

    input_capture #(.DEBOUNCE_CYCLES(4)) dut (
        .sys_clock (sys_clock),
        .reset     (reset),
        .IO        (IO),
        .switches  (switches),
        .key       (key),
        .entrada   (entrada),
        .in_ready  (in_ready),
        .busy      (busy)
    );

    always #HALF sys_clock = ~sys_clock;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge sys_clock);
    endtask

    task automatic wait_ready(input string nm);
        int n = 0;
        while (!in_ready && n < 60) begin
            @(posedge sys_clock);
            n++;
        end
        check(nm, {31'b0, in_ready}, 32'd1);
    endtask

    task automatic press(input int n);
        key = 1'b0;
        cycles(n);
        key = 1'b1;
    endtask

    // Monitor: every rising in_ready must match the oldest expected capture.
    always @(posedge sys_clock) begin
        check("busy_ready_exclusive", {31'b0, busy & in_ready}, 32'd0);
        if (in_ready && !prev_rdy) begin
            if (exp_q.size() == 0) begin
                check("unexpected_in_ready", 32'd1, 32'd0);
            end else begin
                check("entrada_at_ready", {16'b0, entrada}, {16'b0, exp_q.pop_front()});
            end
        end
        prev_rdy = in_ready;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        #2 reset = 1'b1;
        #1;
        check("reset_entrada", {16'b0, entrada}, 32'h0);
        check("reset_busy", {31'b0, busy}, 32'd0);
        check("reset_in_ready", {31'b0, in_ready}, 32'd0);
        cycles(2);
        reset = 1'b0;
        cycles(2);

        // Basic capture and 4-phase handshake
        switches = 16'h1234;
        IO = 2'd1;
        exp_q.push_back(16'h1234);
        cycles(3);
        check("t1_busy_wait", {31'b0, busy}, 32'd1);
        press(10);
        wait_ready("t1_ready");
        check("t1_busy_done", {31'b0, busy}, 32'd0);
        cycles(5);
        check("t1_ready_held", {31'b0, in_ready}, 32'd1);
        IO = 2'd0;
        cycles(1);
        check("t1_ready_drop", {31'b0, in_ready}, 32'd0);
        cycles(3);

        // Short key pulse while waiting for a press
        switches = 16'h4321;
        IO = 2'd1;
        cycles(4);
`ifdef INPUT_CAPTURE_DEBOUNCE_EN
        press(3);
        cycles(15);
        check("t2_busy_after_glitch", {31'b0, busy}, 32'd1);
        check("t2_no_ready", {31'b0, in_ready}, 32'd0);
        check("t2_entrada_kept", {16'b0, entrada}, 32'h1234);
        exp_q.push_back(16'h4321);
        press(10);
`else
        exp_q.push_back(16'h4321);
        press(1);
`endif
        wait_ready("t2_ready");
        IO = 2'd0;
        cycles(3);

        // Key held before the request is not a press
        switches = 16'h00FF;
        key = 1'b0;
        cycles(15);
        IO = 2'd1;
        cycles(10);
        check("t3_busy_held_key", {31'b0, busy}, 32'd1);
        check("t3_no_capture", {16'b0, entrada}, 32'h4321);
        key = 1'b1;
        cycles(10);
        switches = 16'hABCD;
        exp_q.push_back(16'hABCD);
        press(10);
        wait_ready("t3_ready");
        IO = 2'd0;
        cycles(3);

        // Request withdrawn before any press
        switches = 16'h9999;
        IO = 2'd1;
        cycles(5);
        IO = 2'd0;
        cycles(2);
        check("t4_busy", {31'b0, busy}, 32'd0);
        check("t4_in_ready", {31'b0, in_ready}, 32'd0);
        check("t4_entrada_kept", {16'b0, entrada}, 32'hABCD);
        cycles(3);

        // Reset while waiting for release
        switches = 16'h5555;
        IO = 2'd1;
        cycles(3);
        key = 1'b0;
        cycles(10);
        check("t5_busy_release", {31'b0, busy}, 32'd1);
        check("t5_captured", {16'b0, entrada}, 32'h5555);
        reset = 1'b1;
        #1;
        check("t5_reset_entrada", {16'b0, entrada}, 32'h0);
        check("t5_reset_busy", {31'b0, busy}, 32'd0);
        cycles(2);
        reset = 1'b0;
        IO = 2'd0;
        key = 1'b1;
        cycles(10);
        press(10);
        cycles(10);
        check("t5_no_req_entrada", {16'b0, entrada}, 32'h0);
        check("t5_no_req_busy", {31'b0, busy}, 32'd0);
        check("t5_no_req_ready", {31'b0, in_ready}, 32'd0);

        // A fresh request after reset captures normally
        switches = 16'h0F0F;
        IO = 2'd1;
        exp_q.push_back(16'h0F0F);
        cycles(3);
        press(10);
        wait_ready("t6_ready");
        IO = 2'd0;
        cycles(3);

        check("queue_drained", exp_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
